read_empty_logic: RTL

READ_EMPTY_LOGIC -- requirements
Module: read_empty_logic

---
 rtl/fifo_pkg.sv | 29 ++
 rtl/sync_2ff.sv | 33 +++
 rtl/read_empty_logic.sv | 74 +++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared FIFO pointer helpers, used by both the read-side empty logic and
// the write-side full logic.
package fifo_pkg;

  // Working width of the Gray/binary helpers; callers size-cast the result
  // down to their pointer width.
  localparam int unsigned FUNC_W = 32;

  // Pointer width for a given memory address width: one extra bit tells a
  // full FIFO apart from an empty one.
  function automatic int unsigned ptr_width(input int unsigned adr_width);
    return adr_width + 1;
  endfunction

  function automatic logic [FUNC_W-1:0] bin2gray(input logic [FUNC_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Prefix XOR from the MSB down; zero-extended upper bits contribute nothing.
  function automatic logic [FUNC_W-1:0] gray2bin(input logic [FUNC_W-1:0] g);
    logic [FUNC_W-1:0] b;
    b = g;
    for (int unsigned i = 1; i < FUNC_W; i++) begin
      b = b ^ (g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a multi-bit Gray-coded bus crossing into clk.
module sync_2ff #(
  parameter int unsigned width = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [width-1:0] d,
  output logic [width-1:0] q
);

  logic [width-1:0] meta_d, meta_q;
  logic [width-1:0] sync_d, sync_q;

  // Next-state: each stage simply takes the previous one.
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // Both stages clear asynchronously so no stale pointer survives reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/read_empty_logic.sv
// Read-domain empty / almost-empty / occupancy generation for an async FIFO.
module read_empty_logic
  import fifo_pkg::*;
#(
  parameter int unsigned depth     = 8,
  parameter int unsigned adr_width = $clog2(depth),
  parameter int unsigned ae_level  = 1
) (
  input  logic                 clk_r,
  input  logic                 reset,
  input  logic [adr_width:0]   wr_ptr_gray,
  input  logic [adr_width:0]   read_adr,
  input  logic                 read,
  output logic                 FIFO_empty,
  output logic                 almost_empty,
  output logic [adr_width:0]   rd_count,
  output logic [adr_width:0]   rd_ptr_gray
);

  localparam int unsigned PW = ptr_width(adr_width);

  logic [PW-1:0] wr_gray_s;
  logic [PW-1:0] rd_next;
  logic [PW-1:0] rd_gray_next;
  logic [PW-1:0] wr_bin_s;
  logic [PW-1:0] occ;

  logic          fifo_empty_d,   fifo_empty_q;
  logic          almost_empty_d, almost_empty_q;
  logic [PW-1:0] rd_count_d,     rd_count_q;
  logic [PW-1:0] rd_ptr_gray_d,  rd_ptr_gray_q;

  // The write pointer is only ever observed through this synchronizer.
  sync_2ff #(.width(PW)) u_wr_sync (
    .clk   (clk_r),
    .rst_n (reset),
    .d     (wr_ptr_gray),
    .q     (wr_gray_s)
  );

  // Flags are computed against the post-read pointer so a read that drains
  // the last entry shows empty right after the same edge.
  always_comb begin
    rd_next        = read_adr + PW'(read);
    rd_gray_next   = PW'(bin2gray(FUNC_W'(rd_next)));
    wr_bin_s       = PW'(gray2bin(FUNC_W'(wr_gray_s)));
    occ            = wr_bin_s - rd_next;
    rd_ptr_gray_d  = rd_gray_next;
    fifo_empty_d   = (rd_gray_next == wr_gray_s);
    rd_count_d     = occ;
    almost_empty_d = (32'(occ) <= ae_level);
  end

  // Output registers; reset presents an empty FIFO.
  always_ff @(posedge clk_r or negedge reset) begin
    if (!reset) begin
      fifo_empty_q   <= 1'b1;
      almost_empty_q <= 1'b1;
      rd_count_q     <= '0;
      rd_ptr_gray_q  <= '0;
    end else begin
      fifo_empty_q   <= fifo_empty_d;
      almost_empty_q <= almost_empty_d;
      rd_count_q     <= rd_count_d;
      rd_ptr_gray_q  <= rd_ptr_gray_d;
    end
  end

  assign FIFO_empty   = fifo_empty_q;
  assign almost_empty = almost_empty_q;
  assign rd_count     = rd_count_q;
  assign rd_ptr_gray  = rd_ptr_gray_q;

endmodule
